// File: rtl/vga_palette_out.sv
// vga_palette_out: 640x480@60 raster generator and palette back end.
// Publishes the scan position to the mixer, takes the mixer's palette index
// MIX_LATENCY cycles later, and drives colour/sync/blank aligned at the DAC.
module vga_palette_out #(
    parameter int MIX_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frameTick,
    input  logic [4:0]  pixelIndex,
    input  logic        paletteWe,
    input  logic [4:0]  paletteAddr,
    input  logic [23:0] paletteData,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N
);

    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] V_LAST       = 10'd524;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;

    logic [9:0]             hCount;
    logic [9:0]             vCount;
    logic                   visible;
    logic                   hsRaw;
    logic                   vsRaw;
    logic [MIX_LATENCY-1:0] visPipe;
    logic [MIX_LATENCY-1:0] hsPipe;
    logic [MIX_LATENCY-1:0] vsPipe;
    logic [23:0]            palette [32];

    assign DrawX = hCount;
    assign DrawY = vCount;

    // Raster counters: 800 cycles per line, 525 lines per frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hCount <= 10'd0;
            vCount <= 10'd0;
        end else if (hCount == H_LAST) begin
            hCount <= 10'd0;
            vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
        end else begin
            hCount <= hCount + 10'd1;
        end
    end

    // Undelayed visible/sync decode of the current raster position.
    always_comb begin
        visible = (hCount < H_VISIBLE) && (vCount < V_VISIBLE);
        hsRaw   = !((hCount >= H_SYNC_START) && (hCount <= H_SYNC_END));
        vsRaw   = !((vCount == V_SYNC_START) || (vCount == V_SYNC_END));
    end

    // Start-of-vblank pulse, one cycle after the counters sit at (0,480).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frameTick <= 1'b0;
        end else begin
            frameTick <= (hCount == 10'd0) && (vCount == V_VISIBLE);
        end
    end

    // Delay line so the last stage lines up with the mixer's pixelIndex.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            visPipe <= '0;
            hsPipe  <= '1;
            vsPipe  <= '1;
        end else begin
            visPipe[0] <= visible;
            hsPipe[0]  <= hsRaw;
            vsPipe[0]  <= vsRaw;
            for (int i = 1; i < MIX_LATENCY; i++) begin
                visPipe[i] <= visPipe[i-1];
                hsPipe[i]  <= hsPipe[i-1];
                vsPipe[i]  <= vsPipe[i-1];
            end
        end
    end

    // Palette storage; a same-edge lookup still sees the previous contents.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                palette[i] <= 24'h000000;
            end
        end else if (paletteWe) begin
            palette[paletteAddr] <= paletteData;
        end
    end

    // Output register: colour only inside the visible window, sync passthrough.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else begin
            if (visPipe[MIX_LATENCY-1]) begin
                {VGA_R, VGA_G, VGA_B} <= palette[pixelIndex];
            end else begin
                {VGA_R, VGA_G, VGA_B} <= 24'h000000;
            end
            VGA_HS      <= hsPipe[MIX_LATENCY-1];
            VGA_VS      <= vsPipe[MIX_LATENCY-1];
            VGA_BLANK_N <= visPipe[MIX_LATENCY-1];
        end
    end

endmodule

// File: doc/vga_palette_out.md
# vga_palette_out

Display back end of the renderer. Generates 640x480@60 VGA raster timing and publishes the current scan position (DrawX/DrawY) to the sprite/pixel-mixer front end. It accepts the mixer's registered 5-bit palette index a fixed number of cycles later and converts it to 24-bit RGB through a writable 32-entry palette. Sync and blank are delay-matched so that colour and sync reach the DAC aligned.

## Interface
- MIX_LATENCY, 1, cycles from DrawX/DrawY valid to matching pixelIndex valid; legal range 1..4.
- Clk  in  1  pixel clock (25 MHz); all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- DrawX  out  10  current horizontal count, 0..799.
- DrawY  out  10  current vertical count, 0..524.
- frameTick  out  1  one-cycle pulse at start of vertical blank.
- pixelIndex  in  5  palette index from mixer, valid MIX_LATENCY cycles after its DrawX/DrawY.
- paletteWe  in  1  palette write strobe.
- paletteAddr  in  5  palette write address.
- paletteData  in  24  write data {R[23:16], G[15:8], B[7:0]}.
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour.
- VGA_HS  out  1  horizontal sync, active-low.
- VGA_VS  out  1  vertical sync, active-low.
- VGA_BLANK_N  out  1  high only during visible pixels.

## Operation
- Raster counters:
  - hCount increments every cycle and wraps 799 -> 0.
  - vCount increments when hCount wraps, and wraps 524 -> 0.
  - DrawX = hCount and DrawY = vCount, both taken directly from the registers.
- Per-position raw controls:
  - visible = (hCount < 640) && (vCount < 480).
  - hsRaw = 0 for hCount 656..751.
  - vsRaw = 0 for vCount 490..491.
- Delay line:
  - visible, hsRaw and vsRaw pass through a shift register of MIX_LATENCY stages.
  - The stage-MIX_LATENCY values are aligned with pixelIndex.
- Output register (updates every cycle):
  - RGB = palette[pixelIndex] when the delayed visible is 1, otherwise 0.
  - VGA_BLANK_N, VGA_HS and VGA_VS take the delayed visible, hsRaw and vsRaw.
- Palette:
  - 32 x 24-bit registers.
  - A write with paletteWe=1 updates entry paletteAddr at the clock edge.
  - Index 5'h15 (the mixer's transparent/background code) is an ordinary entry, with no special handling.
- Read/write same cycle, same address: the lookup uses the old contents; the new value is visible from the next cycle.
- pixelIndex is ignored during blanking, and the palette stays writable at all times.
- frameTick:
  - Registered.
  - Asserted for exactly one cycle, in the cycle after the counters hold (0, 480).
  - Exactly once per 420000-cycle frame.

## Timing
- Reset values:
  - Counters 0 and frameTick 0.
  - All palette entries 24'h000000.
  - VGA_R/G/B 0, VGA_HS 1, VGA_VS 1, VGA_BLANK_N 0.
  - Delay-line stages load visible=0, hs=1, vs=1.
- Reset asserted mid-line forces the state above immediately. After release, counting restarts at (0,0) on the first rising edge.
- Latency:
  - DrawX/DrawY to VGA pins is MIX_LATENCY+1 cycles.
  - pixelIndex to RGB is 1 cycle.
  - Palette write to usable in lookup is 1 cycle.
- Line is 800 cycles, frame is 525 lines; no stall or back-pressure exists.
- HS low pulse is 96 cycles; VS low pulse is 1600 cycles (2 lines); both appear MIX_LATENCY+1 cycles after the raw position.

## Test plan
- **Reset:** hold Reset 5 cycles, then release.
  - During reset: DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0.
  - After the first edge following release: DrawX=1.
- **Wrap:** run 800 cycles, then 420000 cycles from reset.
  - After 800 cycles: DrawX=0, DrawY=1.
  - After 420000 cycles: DrawX=0, DrawY=0.
  - frameTick counted exactly once per frame, one cycle after (0,480).
- **Sync alignment (MIX_LATENCY=1 and 3):**
  - VGA_HS falls MIX_LATENCY+1 cycles after DrawX=656 and stays low 96 cycles.
  - VGA_VS is low for exactly 1600 cycles per frame.
  - VGA_BLANK_N is high for 640 cycles per visible line.
- **Palette lookup:**
  - Stimulus: write entry 5'h06 = 24'hFF0000; drive pixelIndex=5'h06 aligned to DrawX=10, DrawY=5.
  - Response: VGA_R/G/B = FF/00/00 at the pins MIX_LATENCY+1 cycles after DrawX=10.
  - The same index aligned to DrawX=700 yields RGB 0.
- **Write/read collision:**
  - Stimulus: entry 5'h15 = 24'h0000FF; in the same cycle, write 24'h00FF00 to 5'h15 while pixelIndex=5'h15 is in a visible slot.
  - Response: that pixel outputs 0000FF; the next pixel with index 5'h15 outputs 00FF00.
- **Reset mid-frame:**
  - Stimulus: assert Reset at DrawX=300, DrawY=200 with non-zero palette.
  - Response: outputs return to reset values within the same cycle, and all palette entries read 0 afterwards.
